selector_n1_rr: RTL and testbench
=================================

Name: selector_n1_rr

Overview:
- Parametrised, registered N:1 word selector.
- Successor to the fixed 4-input combinational selector used on datapath operand and writeback paths.
- Adds per-channel valid/ready handshakes and a registered output stage with downstream backpressure.
- Two modes: direct (select-driven) and round-robin arbitration. Used where several producers share one datapath port.

Parameters:
- WIDTH, 32, data word width in bits.
- NCH, 4, number of input channels (2..2**SEL_W).
- SEL_W, 2, width of the select input and of the channel-index output.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iC  input  NCH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- iValid  input  NCH  per-channel valid.
- oReady  output  NCH  per-channel ready (grant), combinational.
- iMode  input  1  0 = direct select, 1 = round-robin.
- iSel  input  SEL_W  channel index used in direct mode.
- oZ  output  WIDTH  registered selected word.
- oValid  output  1  oZ holds an unconsumed word.
- oCh  output  SEL_W  index of the channel that supplied oZ.
- iReady  input  1  downstream accepts oZ this cycle.
- oSelErr  output  1  registered one-cycle flag: direct-mode select was out of range.

Behaviour:
- Reset (async, iRst_n = 0): oZ = 0, oValid = 0, oCh = 0, oSelErr = 0, round-robin pointer ptr = 0. Outputs hold these values until the first rising edge after deassertion. Reset mid-transfer discards the held word.
- load = ~oValid | iReady. The output register can take a new word this cycle (empty, or being drained). Gives full throughput of 1 word/cycle under continuous iReady.
- Grant (combinational, at most one bit set; all zero when load = 0):
  - Direct mode: grant channel iSel if iSel < NCH and iValid[iSel] = 1; otherwise no grant.
  - Round-robin mode: scan channels ptr, ptr+1, …, NCH-1, 0, …, ptr-1. Grant the first with iValid = 1. No valid channel → no grant.
- oReady = grant. A channel transfers when iValid[k] & oReady[k].
- Rising edge with load = 1 and a grant to channel k:
  - oZ <= iC[k], oCh <= k, oValid <= 1.
  - Round-robin mode only: ptr <= k+1, wrapping to 0 when k = NCH-1.
- Rising edge with load = 1 and no grant: oValid <= 0; oZ and oCh hold their previous values.
- Rising edge with load = 0 (oValid = 1 and iReady = 0): oZ, oCh, oValid and ptr hold. No channel sees ready.
- Latency: 1 cycle from transfer at a channel to oValid/oZ.
- ptr changes only on a round-robin-mode transfer. Direct-mode traffic leaves it untouched.
- Mode switch takes effect in the same cycle's grant logic. Does not reset ptr. Does not disturb a held output word.
- oSelErr <= (iMode = 0) & (iSel >= NCH) & load, every edge. It is never sticky.
- Simultaneous drain and refill (oValid = 1, iReady = 1, grant present): the new word replaces the old in one edge, oValid stays 1.
- iValid on a channel without grant: no state change. The channel must hold its data; the block imposes no drop.
- Data is passed unmodified. No width conversion.

Test Plan:
- Reset: assert iRst_n = 0 mid-cycle with oValid = 1 → oZ = 0, oValid = 0, oCh = 0, oSelErr = 0 immediately, without waiting for a clock edge.
- Direct mode, all iValid = 1, iReady = 1, iSel stepping 0,1,2,3, iC[k] = 32'hA000_000k → oZ = A0000000..A0000003 one cycle later, oCh = 0..3, oReady one-hot matching iSel.
- Backpressure: direct iSel = 2, iReady = 0 for 3 cycles after the first capture → oZ holds iC[2], oReady = 0000 while stalled; the next word is captured on the cycle iReady returns to 1.
- Round-robin, iValid = 4'b1011 constant, iReady = 1 → oCh sequence 0,1,3,0,1,3; ptr wraps after channel 3.
- Out-of-range select: NCH = 3, SEL_W = 2, iSel = 3, iMode = 0 → no grant, oSelErr = 1 for one cycle, oValid = 0 on the next edge.
- Mode switch: round-robin after a grant to channel 1 (ptr = 2), then 2 direct cycles with iSel = 0, then back to round-robin with all valid → the next round-robin grant is channel 2.

Source files
------------

// File: rtl/selector_n1_rr.sv
// selector_n1_rr: registered N:1 word selector with valid/ready
// channels, direct-select or round-robin grant, output backpressure.
module selector_n1_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [NCH*WIDTH-1:0] iC,
  input  logic [NCH-1:0]       iValid,
  output logic [NCH-1:0]       oReady,
  input  logic                 iMode,
  input  logic [SEL_W-1:0]     iSel,
  output logic [WIDTH-1:0]     oZ,
  output logic                 oValid,
  output logic [SEL_W-1:0]     oCh,
  input  logic                 iReady,
  output logic                 oSelErr
);

  logic             load;
  logic             hit;
  logic             selOk;
  logic [SEL_W-1:0] gIdx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptrNext;
  logic [WIDTH-1:0] gData;

  assign load = ~oValid | iReady;

  // direct select names an existing channel
  always_comb begin
    selOk = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (iSel == SEL_W'(k)) selOk = 1'b1;
    end
  end

  // pick the granted channel for this cycle
  always_comb begin
    int c;
    hit  = 1'b0;
    gIdx = '0;
    c    = 0;
    if (load) begin
      if (!iMode) begin
        for (int k = 0; k < NCH; k++) begin
          if (iSel == SEL_W'(k) && iValid[k]) begin
            hit  = 1'b1;
            gIdx = SEL_W'(k);
          end
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          c = int'(ptr) + i;
          if (c >= NCH) c = c - NCH;
          for (int k = 0; k < NCH; k++) begin
            if (!hit && c == k && iValid[k]) begin
              hit  = 1'b1;
              gIdx = SEL_W'(k);
            end
          end
        end
      end
    end
  end

  // one-hot ready and data mux from the grant
  always_comb begin
    oReady = '0;
    gData  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (hit && gIdx == SEL_W'(k)) begin
        oReady[k] = 1'b1;
        gData     = iC[k*WIDTH +: WIDTH];
      end
    end
  end

  // pointer advances past the winner on round-robin transfers only
  always_comb begin
    ptrNext = ptr;
    if (hit && iMode) begin
      if (gIdx == SEL_W'(NCH - 1)) ptrNext = '0;
      else                         ptrNext = gIdx + SEL_W'(1);
    end
  end

  // output register, pointer and select-error flag
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oZ      <= '0;
      oValid  <= 1'b0;
      oCh     <= '0;
      oSelErr <= 1'b0;
      ptr     <= '0;
    end else begin
      oSelErr <= ~iMode & ~selOk & load;
      ptr     <= ptrNext;
      if (load) begin
        if (hit) begin
          oZ     <= gData;
          oCh    <= gIdx;
          oValid <= 1'b1;
        end else begin
          oValid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_selector_n1_rr.sv
// tb_selector_n1_rr: directed and random checks of selector_n1_rr
// against a queue-free behavioural model, for NCH=4 and NCH=3.
module tb_selector_n1_rr;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  logic [127:0] c4;
  logic [3:0]   v4, r4;
  logic         m4, rdy4, ov4, e4;
  logic [1:0]   s4, ch4;
  logic [31:0]  z4;

  logic [95:0]  c3;
  logic [2:0]   v3, r3;
  logic         m3, rdy3, ov3, e3;
  logic [1:0]   s3, ch3;
  logic [31:0]  z3;

  selector_n1_rr #(.WIDTH(32), .NCH(4), .SEL_W(2)) u4 (
    .iClk(iClk), .iRst_n(iRst_n), .iC(c4), .iValid(v4),
    .oReady(r4), .iMode(m4), .iSel(s4), .oZ(z4),
    .oValid(ov4), .oCh(ch4), .iReady(rdy4), .oSelErr(e4)
  );

  selector_n1_rr #(.WIDTH(32), .NCH(3), .SEL_W(2)) u3 (
    .iClk(iClk), .iRst_n(iRst_n), .iC(c3), .iValid(v3),
    .oReady(r3), .iMode(m3), .iSel(s3), .oZ(z3),
    .oValid(ov3), .oCh(ch3), .iReady(rdy3), .oSelErr(e3)
  );

  int checks = 0;
  int failures = 0;

  // stimulus per instance (0 = NCH 4, 1 = NCH 3)
  bit          sMode[2];
  int          sSel[2];
  logic [3:0]  sValid[2];
  bit          sRdy[2];
  logic [31:0] sDat[2][4];

  // behavioural model state
  logic [31:0] mZ[2];
  bit          mV[2];
  int          mCh[2];
  int          mPtr[2];
  bit          mErr[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nCh(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int modelGrant(input int d);
    int n;
    n = nCh(d);
    if (mV[d] && !sRdy[d]) return -1;
    if (!sMode[d]) begin
      if (sSel[d] < n && sValid[d][sSel[d]]) return sSel[d];
      return -1;
    end
    for (int i = 0; i < n; i++) begin
      if (sValid[d][(mPtr[d] + i) % n]) return (mPtr[d] + i) % n;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mZ[d] = '0; mV[d] = 0; mCh[d] = 0; mPtr[d] = 0; mErr[d] = 0;
    end
  endtask

  task automatic applyIn();
    c4   = {sDat[0][3], sDat[0][2], sDat[0][1], sDat[0][0]};
    v4   = sValid[0];
    m4   = sMode[0];
    s4   = 2'(sSel[0]);
    rdy4 = sRdy[0];
    c3   = {sDat[1][2], sDat[1][1], sDat[1][0]};
    v3   = sValid[1][2:0];
    m3   = sMode[1];
    s3   = 2'(sSel[1]);
    rdy3 = sRdy[1];
  endtask

  task automatic checkOut();
    chk("valid4", {31'b0, ov4}, {31'b0, mV[0]});
    chk("z4", z4, mZ[0]);
    chk("ch4", {30'b0, ch4}, 32'(mCh[0]));
    chk("err4", {31'b0, e4}, {31'b0, mErr[0]});
    chk("valid3", {31'b0, ov3}, {31'b0, mV[1]});
    chk("z3", z3, mZ[1]);
    chk("ch3", {30'b0, ch3}, 32'(mCh[1]));
    chk("err3", {31'b0, e3}, {31'b0, mErr[1]});
  endtask

  task automatic cycle();
    int  g[2];
    bit  ld;
    applyIn();
    #1;
    for (int d = 0; d < 2; d++) g[d] = modelGrant(d);
    chk("ready4", {28'b0, r4}, (g[0] < 0) ? 32'd0 : 32'd1 << g[0]);
    chk("ready3", {29'b0, r3}, (g[1] < 0) ? 32'd0 : 32'd1 << g[1]);
    @(posedge iClk);
    #1;
    for (int d = 0; d < 2; d++) begin
      ld = !mV[d] || sRdy[d];
      mErr[d] = !sMode[d] && sSel[d] >= nCh(d) && ld;
      if (ld) begin
        if (g[d] >= 0) begin
          mZ[d]  = sDat[d][g[d]];
          mCh[d] = g[d];
          mV[d]  = 1;
          if (sMode[d]) mPtr[d] = (g[d] + 1) % nCh(d);
        end else begin
          mV[d] = 0;
        end
      end
    end
    checkOut();
  endtask

  int rrExp[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    for (int d = 0; d < 2; d++) begin
      sMode[d] = 0; sSel[d] = 0; sValid[d] = '0; sRdy[d] = 1;
      for (int k = 0; k < 4; k++) sDat[d][k] = 32'hA000_0000 | k;
    end
    modelReset();
    applyIn();
    #3;
    checkOut();
    #5 iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    checkOut();

    // direct mode, select stepping over all channels
    sValid[0] = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sSel[0] = s;
      cycle();
    end

    // backpressure on channel 2
    sSel[0] = 2;
    cycle();
    sRdy[0] = 0;
    sSel[0] = 3;
    repeat (3) cycle();
    chk("bpHold", z4, 32'hA000_0002);
    sRdy[0] = 1;
    cycle();
    chk("bpNext", z4, 32'hA000_0003);

    // round-robin with a gap at channel 2
    sMode[0] = 1;
    sValid[0] = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rrSeq", {30'b0, ch4}, 32'(rrExp[i]));
    end

    // out-of-range select on the 3-channel instance
    sValid[1] = 4'b0111;
    sSel[1] = 1;
    cycle();
    sSel[1] = 3;
    cycle();
    chk("selErr", {31'b0, e3}, 32'd1);
    chk("selErrV", {31'b0, ov3}, 32'd0);
    sSel[1] = 0;
    cycle();
    chk("selErrClr", {31'b0, e3}, 32'd0);

    // mode switch keeps the pointer
    sMode[0] = 1;
    sValid[0] = 4'b0010;
    cycle();
    sMode[0] = 0;
    sSel[0] = 0;
    sValid[0] = 4'b1111;
    repeat (2) cycle();
    sMode[0] = 1;
    cycle();
    chk("modeSw", {30'b0, ch4}, 32'd2);

    // reset while a word is held under backpressure
    sMode[0] = 0;
    sSel[0] = 1;
    sRdy[0] = 0;
    repeat (2) cycle();
    #2 iRst_n = 1'b0;
    #1;
    modelReset();
    checkOut();
    #2 iRst_n = 1'b1;
    sRdy[0] = 1;
    cycle();

    // random traffic on both instances
    for (int t = 0; t < 400; t++) begin
      for (int d = 0; d < 2; d++) begin
        sMode[d]  = bit'($urandom_range(0, 1));
        sSel[d]   = int'($urandom_range(0, 3));
        sValid[d] = 4'($urandom_range(0, 15));
        sRdy[d]   = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) sDat[d][k] = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
